// File: rtl/mac_result_drain_pkg.sv
// ---------------------------------------------------------------------------
// mac_result_drain_pkg
//
// Purpose : shared types and defaults for the MAC result drain and for the
//           feeder block that will sit in front of the same PE row. The state
//           encodings are fixed values so that both blocks (and any debug
//           tooling that reads the state register) agree on them.
//
// Contents: drain_state_e  FSM state encoding (IDLE=0, WAIT=1, DRAIN=2)
//           DEF_*          default parameter values for the PE row
//           idx_width()    width of a PE index, never less than one bit
// ---------------------------------------------------------------------------
package mac_result_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NUM_PE = 4;
    localparam int DEF_CNT_W  = 16;

    // A one-PE row still needs a one-bit index port.
    function automatic int idx_width(input int num_pe);
        return (num_pe > 1) ? $clog2(num_pe) : 1;
    endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// ---------------------------------------------------------------------------
// mac_result_drain_if
//
// Purpose : valid/ready result stream from the drain to the result buffer or
//           host interface. One transfer happens on every rising clock edge
//           where m_valid and m_ready are both high.
//
// Signals : m_valid  word available (driven by master)
//           m_ready  downstream accepts word (driven by slave)
//           m_data   result word, DATA_W bits
//           m_index  PE index of m_data, IDX_W bits
//           m_last   marks the word of the final PE in the row
//
// Modports: master  the drain side
//           slave   the consumer side
// ---------------------------------------------------------------------------
interface mac_result_drain_if
    import mac_result_drain_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = idx_width(DEF_NUM_PE)
) ();

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [IDX_W-1:0]  m_index;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/mac_result_drain.sv
// ---------------------------------------------------------------------------
// mac_result_drain
//
// Purpose : read-side companion of the systolic MAC PE row. After a pass of
//           k_len accumulate steps it waits out the systolic skew, snapshots
//           the out_c accumulators of all NUM_PE PEs into a shadow bank,
//           pulses a clear to the PE row, and streams the snapshot one word
//           per accepted transfer over a valid/ready master port.
//
// Ports   : clk         single clock, rising edge
//           rst_n       asynchronous active-low reset
//           start_i     begin a pass (only looked at while idle)
//           k_len_i     accumulate steps of the pass, sampled with start_i
//           acc_in_i    PE out_c values, PE i at [i*DATA_W +: DATA_W]
//           pe_clear_o  one-cycle clear to the PE row, first DRAIN cycle
//           busy_o      high whenever the drain is not idle
//           done_o      one-cycle pulse after the last word is accepted
//           m_if        result stream (master modport)
//
// Timing  : start seen on edge 0 -> WAIT for k_len+NUM_PE cycles -> first
//           m_valid in cycle k_len+NUM_PE+1, together with pe_clear_o.
// ---------------------------------------------------------------------------
module mac_result_drain
    import mac_result_drain_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [CNT_W-1:0]         k_len_i,
    input  logic [NUM_PE*DATA_W-1:0] acc_in_i,
    output logic                     pe_clear_o,
    output logic                     busy_o,
    output logic                     done_o,
    mac_result_drain_if.master       m_if
);

    localparam int IDX_W = idx_width(NUM_PE);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    // Skew of the row: the last PE finishes NUM_PE-1 cycles after the first.
    localparam logic [CNT_W:0]   SKEW     = (CNT_W + 1)'(NUM_PE - 1);
    localparam logic [CNT_W:0]   CNT_ONE  = (CNT_W + 1)'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    drain_state_e      state_q, state_d;
    // One extra bit so k_len + NUM_PE - 1 never wraps, even for k_len = max.
    logic [CNT_W:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              clr_q, clr_d;
    logic              done_q, done_d;
    logic              capture;

    logic [DATA_W-1:0] acc_word [NUM_PE];
    logic [DATA_W-1:0] shadow_q [NUM_PE];

    // Split the flat PE bus into one word per PE.
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_unpack
        assign acc_word[gi] = acc_in_i[gi*DATA_W +: DATA_W];
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = {1'b0, k_len_i} + SKEW;
                end
            end

            ST_WAIT: begin
                // Snapshot on the edge where the counter has run out; the
                // clear is registered so the PE row sees it for exactly the
                // first DRAIN cycle.
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    clr_d   = 1'b1;
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_DRAIN: begin
                if (m_if.m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
        end
    end

    // Shadow bank: loaded once per pass and then frozen, so the PE row may
    // start its next pass while the previous results are still streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PE; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (capture) begin
            shadow_q <= acc_word;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Every stream output comes straight from registers, so data, index and
    // last stay stable while a word waits for m_ready.
    assign m_if.m_valid  = (state_q == ST_DRAIN);
    assign m_if.m_data   = shadow_q[idx_q];
    assign m_if.m_index  = idx_q;
    // Gated by DRAIN: with NUM_PE=1 the index is always the last one.
    assign m_if.m_last   = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);

    assign pe_clear_o    = clr_q;
    assign done_o        = done_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_result_drain.sv
`timescale 1ns/1ps
module tb_mac_result_drain;
    import mac_result_drain_pkg::*;

    localparam int DW = 32;
    localparam int NP = 4;
    localparam int CW = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main DUT: NUM_PE=4, DATA_W=32, CNT_W=16
    logic              start;
    logic [CW-1:0]     k_len;
    logic [NP*DW-1:0]  acc_in;
    logic              pe_clear, busy, done;
    mac_result_drain_if #(.DATA_W(DW), .IDX_W(IW)) m_if ();

    mac_result_drain #(.DATA_W(DW), .NUM_PE(NP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .k_len_i(k_len),
        .acc_in_i(acc_in), .pe_clear_o(pe_clear), .busy_o(busy),
        .done_o(done), .m_if(m_if)
    );

    // DUT B: NUM_PE=2, narrow counter to exercise the no-wrap rule quickly
    logic        start_b;
    logic [3:0]  k_b;
    logic [15:0] acc_b;
    logic        clr_b, busy_b, done_b;
    mac_result_drain_if #(.DATA_W(8), .IDX_W(1)) mb_if ();

    mac_result_drain #(.DATA_W(8), .NUM_PE(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .k_len_i(k_b),
        .acc_in_i(acc_b), .pe_clear_o(clr_b), .busy_o(busy_b),
        .done_o(done_b), .m_if(mb_if)
    );

    // DUT C: NUM_PE=1
    logic        start_c;
    logic [3:0]  k_c;
    logic [7:0]  acc_c;
    logic        clr_c, busy_c, done_c;
    mac_result_drain_if #(.DATA_W(8), .IDX_W(1)) mc_if ();

    mac_result_drain #(.DATA_W(8), .NUM_PE(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start_i(start_c), .k_len_i(k_c),
        .acc_in_i(acc_c), .pe_clear_o(clr_c), .busy_o(busy_c),
        .done_o(done_c), .m_if(mc_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Table of per-cycle vectors for the basic and backpressure passes
    // -----------------------------------------------------------------------
    typedef struct {
        logic        rdy;
        logic        vld;
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
        logic        clr;
        logic        dn;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rdy, input logic vld, input logic [31:0] data,
                                input logic [1:0] idx, input logic last, input logic clr,
                                input logic dn, input logic bsy);
        vec_t v;
        v.rdy = rdy; v.vld = vld; v.data = data; v.idx = idx;
        v.last = last; v.clr = clr; v.dn = dn; v.bsy = bsy;
        return v;
    endfunction

    localparam logic [NP*DW-1:0] ACC1 = {32'h40, 32'h30, 32'h20, 32'h10};

    task automatic fill_table();
        // Pass 1 (rows 0..12 = cycles 1..13): k_len=3, always ready
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h10, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 32'h20, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h30, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h40, 3, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        // Pass 2 (rows 13..31 = cycles 1..19): ready low 8-10, then toggling
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h10, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h20, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h20, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h30, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h30, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h40, 3, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h40, 3, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Called at a negedge while idle; row i describes cycle (i-first+1).
    task automatic run_table(input int first, input int last, input string tag);
        int c;
        start = 1'b1; k_len = 16'd3; acc_in = ACC1;
        @(negedge clk);
        start = 1'b0;
        k_len = CW'($urandom);
        c = 1;
        for (int i = first; i <= last; i++) begin
            check($sformatf("%s.c%0d.valid", tag, c), m_if.m_valid, tbl[i].vld);
            check($sformatf("%s.c%0d.busy", tag, c), busy, tbl[i].bsy);
            check($sformatf("%s.c%0d.pe_clear", tag, c), pe_clear, tbl[i].clr);
            check($sformatf("%s.c%0d.done", tag, c), done, tbl[i].dn);
            if (tbl[i].vld) begin
                check($sformatf("%s.c%0d.data", tag, c), m_if.m_data, tbl[i].data);
                check($sformatf("%s.c%0d.index", tag, c), m_if.m_index, tbl[i].idx);
                check($sformatf("%s.c%0d.last", tag, c), m_if.m_last, tbl[i].last);
            end
            m_if.m_ready = tbl[i].rdy;
            if (tbl[i].vld && tbl[i].rdy)
                $display("%s cycle %0d word idx=%0d data=0x%08h last=%0d",
                         tag, c, m_if.m_index, m_if.m_data, m_if.m_last);
            @(negedge clk);
            c++;
        end
    endtask

    function automatic logic [NP*DW-1:0] rnd_acc();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // -----------------------------------------------------------------------
    // Randomized pass against a reference model: the words streamed are the
    // acc_in values present at the edge k+NP after start, in PE order, the
    // first one appearing in cycle k+NP+1; done follows the last acceptance.
    // -----------------------------------------------------------------------
    task automatic rand_pass(input int k, input bit corrupt, input bit stray, input string tag);
        int c, cap_c, n_acc, fin_c;
        bit exp_vld;
        logic [DW-1:0] exp_w [NP];
        logic [NP*DW-1:0] a;
        for (int i = 0; i < NP; i++) exp_w[i] = '0;
        start = 1'b1; k_len = CW'(k); acc_in = rnd_acc();
        m_if.m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        c = 1; cap_c = k + NP; n_acc = 0; fin_c = 0;
        forever begin
            exp_vld = (c > cap_c) && (n_acc < NP);
            check($sformatf("%s.c%0d.valid", tag, c), m_if.m_valid, exp_vld);
            check($sformatf("%s.c%0d.busy", tag, c), busy, fin_c == 0);
            check($sformatf("%s.c%0d.pe_clear", tag, c), pe_clear, c == cap_c + 1);
            check($sformatf("%s.c%0d.done", tag, c), done, (fin_c != 0) && (c == fin_c + 1));
            if (exp_vld) begin
                check($sformatf("%s.c%0d.data", tag, c), m_if.m_data, exp_w[n_acc]);
                check($sformatf("%s.c%0d.index", tag, c), m_if.m_index, n_acc);
                check($sformatf("%s.c%0d.last", tag, c), m_if.m_last, n_acc == NP - 1);
            end
            if (fin_c != 0) break;
            if (c > cap_c + 8 * NP + 64) begin
                checks++; errors++;
                $display("FAIL %s.timeout: actual %0d words required %0d", tag, n_acc, NP);
                break;
            end
            a = rnd_acc();
            if (c == cap_c) begin
                for (int i = 0; i < NP; i++) exp_w[i] = a[i*DW +: DW];
            end else if (corrupt && c > cap_c) begin
                a = '1;
            end
            acc_in = a;
            m_if.m_ready = ($urandom_range(0, 3) != 0);
            if (exp_vld && m_if.m_ready) begin
                $display("%s cycle %0d word idx=%0d data=0x%08h last=%0d",
                         tag, c, m_if.m_index, m_if.m_data, m_if.m_last);
                n_acc++;
                if (n_acc == NP) fin_c = c;
            end
            start = stray ? ($urandom_range(0, 2) == 0) : 1'b0;
            k_len = CW'($urandom);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
    endtask

    task automatic reset_test();
        // Reset during the pe_clear cycle
        start = 1'b1; k_len = 16'd2; acc_in = rnd_acc(); m_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 + NP) @(negedge clk);
        check("rstA.pre_clear", pe_clear, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstA.pe_clear", pe_clear, 1'b0);
        check("rstA.valid", m_if.m_valid, 1'b0);
        check("rstA.busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // Reset after two accepted words
        start = 1'b1; k_len = 16'd2; acc_in = rnd_acc();
        @(negedge clk);
        start = 1'b0;
        repeat (2 + NP + 2) @(negedge clk);
        check("rstB.pre_valid", m_if.m_valid, 1'b1);
        check("rstB.pre_index", m_if.m_index, 2);
        rst_n = 1'b0;
        #1;
        check("rstB.valid", m_if.m_valid, 1'b0);
        check("rstB.busy", busy, 1'b0);
        check("rstB.done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstB.after%0d.done", i), done, 1'b0);
            check($sformatf("rstB.after%0d.valid", i), m_if.m_valid, 1'b0);
            check($sformatf("rstB.after%0d.busy", i), busy, 1'b0);
        end
    endtask

    // k_len at its maximum: 15 + 2 - 1 = 16 needs the extra counter bit.
    task automatic test_b();
        start_b = 1'b1; k_b = 4'hF; acc_b = 16'hA55A; mb_if.m_ready = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("B.c%0d.valid", c), mb_if.m_valid, 1'b0);
            check($sformatf("B.c%0d.busy", c), busy_b, 1'b1);
            @(negedge clk);
        end
        check("B.c18.valid", mb_if.m_valid, 1'b1);
        check("B.c18.pe_clear", clr_b, 1'b1);
        check("B.c18.data", mb_if.m_data, 8'h5A);
        check("B.c18.index", mb_if.m_index, 1'b0);
        check("B.c18.last", mb_if.m_last, 1'b0);
        $display("B cycle 18 word idx=%0d data=0x%02h", mb_if.m_index, mb_if.m_data);
        @(negedge clk);
        check("B.c19.data", mb_if.m_data, 8'hA5);
        check("B.c19.index", mb_if.m_index, 1'b1);
        check("B.c19.last", mb_if.m_last, 1'b1);
        $display("B cycle 19 word idx=%0d data=0x%02h", mb_if.m_index, mb_if.m_data);
        @(negedge clk);
        check("B.c20.done", done_b, 1'b1);
        check("B.c20.valid", mb_if.m_valid, 1'b0);
        check("B.c20.busy", busy_b, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_c();
        start_c = 1'b1; k_c = 4'd2; acc_c = 8'hC3; mc_if.m_ready = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("C.c%0d.valid", c), mc_if.m_valid, 1'b0);
            @(negedge clk);
        end
        check("C.c4.valid", mc_if.m_valid, 1'b1);
        check("C.c4.pe_clear", clr_c, 1'b1);
        check("C.c4.data", mc_if.m_data, 8'hC3);
        check("C.c4.index", mc_if.m_index, 1'b0);
        check("C.c4.last", mc_if.m_last, 1'b1);
        $display("C cycle 4 word idx=%0d data=0x%02h", mc_if.m_index, mc_if.m_data);
        @(negedge clk);
        check("C.c5.done", done_c, 1'b1);
        check("C.c5.valid", mc_if.m_valid, 1'b0);
        check("C.c5.busy", busy_c, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; k_len = '0; acc_in = '0; m_if.m_ready = 1'b0;
        start_b = 1'b0; k_b = '0; acc_b = '0; mb_if.m_ready = 1'b0;
        start_c = 1'b0; k_c = '0; acc_c = '0; mc_if.m_ready = 1'b0;
        fill_table();
        @(negedge clk);
        @(negedge clk);
        check("reset.busy", busy, 1'b0);
        check("reset.valid", m_if.m_valid, 1'b0);
        check("reset.pe_clear", pe_clear, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.data", m_if.m_data, 32'h0);
        check("reset.index", m_if.m_index, 2'd0);
        check("reset.last", m_if.m_last, 1'b0);
        check("reset.b_valid", mb_if.m_valid, 1'b0);
        check("reset.c_valid", mc_if.m_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_table(0, 12, "basic");
        run_table(13, 31, "bp");
        rand_pass(0, 1'b0, 1'b0, "k0");
        for (int p = 0; p < 10; p++)
            rand_pass($urandom_range(0, 12), (p % 2) == 1, p >= 4, $sformatf("rnd%0d", p));
        reset_test();
        rand_pass(3, 1'b1, 1'b1, "post_rst");
        test_b();
        test_c();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
